// File: rtl/lsu_ram_ctrl.sv
// Load/store unit front-end for a single-port synchronous RAM with RD_LAT read latency.
// Handles RV32I byte/half/word loads and stores; sub-word stores use read-modify-write.
module lsu_ram_ctrl #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [12:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [10:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  lane_reg;
  logic [15:0] wdata_reg;

  logic        ram_wren_reg, ram_wren_next;
  logic [10:0] ram_address_reg, ram_address_next;
  logic [31:0] ram_data_reg, ram_data_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;

  logic accept;
  logic req_bad;
  logic req_is_sw;

  function automatic logic is_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:         bad = 1'b0;
      3'b001, 3'b101: bad = a[0];
      3'b010:         bad = (a != 2'b00);
      3'b100:         bad = 1'b0;
      default:        bad = 1'b1;
    endcase
    // Unsigned widths only make sense for loads.
    if (we && f3[2]) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] q, input logic [2:0] f3, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = q[{lane, 3'b000} +: 8];
    h = lane[1] ? q[31:16] : q[15:0];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = q;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] q, input logic [2:0] f3, input logic [1:0] lane,
                                        input logic [15:0] wd);
    logic [31:0] r;
    r = q;
    if (f3[0]) begin
      if (lane[1]) r[31:16] = wd;
      else         r[15:0]  = wd;
    end else begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  assign accept    = req_valid && (state_reg == IDLE);
  assign req_bad   = is_bad(req_we, req_funct3, req_addr[1:0]);
  assign req_is_sw = req_we && (req_funct3 == 3'b010);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_bad)        state_next = RESP;
          else if (req_is_sw) state_next = WRITE;
          else                state_next = READ;
        end
      end
      // Sub-word stores leave one cycle early so MERGE sees the first valid ram_q.
      READ: begin
        if (we_reg && cnt_reg == 3'(RD_LAT - 1))       state_next = MERGE;
        else if (!we_reg && cnt_reg == 3'(RD_LAT))     state_next = RESP;
      end
      MERGE:   state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_address_next = ram_address_reg;
    ram_data_next    = ram_data_reg;
    ram_wren_next    = 1'b0;
    rsp_valid_next   = 1'b0;
    rsp_err_next     = 1'b0;
    rsp_rdata_next   = rsp_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          ram_address_next = req_addr[12:2];
          if (req_bad) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end else if (req_is_sw) begin
            ram_wren_next = 1'b1;
            ram_data_next = req_wdata;
          end
        end
      end
      READ: begin
        if (!we_reg && cnt_reg == 3'(RD_LAT)) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = extend(ram_q, funct3_reg, lane_reg);
        end
      end
      MERGE: begin
        ram_wren_next = 1'b1;
        ram_data_next = merge(ram_q, funct3_reg, lane_reg, wdata_reg);
      end
      WRITE:   rsp_valid_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wren_reg    <= 1'b0;
      ram_address_reg <= '0;
      ram_data_reg    <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_rdata_reg   <= '0;
      cnt_reg         <= '0;
      we_reg          <= 1'b0;
      funct3_reg      <= '0;
      lane_reg        <= '0;
      wdata_reg       <= '0;
    end else begin
      ram_wren_reg    <= ram_wren_next;
      ram_address_reg <= ram_address_next;
      ram_data_reg    <= ram_data_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      if (accept) begin
        cnt_reg    <= '0;
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        lane_reg   <= req_addr[1:0];
        wdata_reg  <= req_wdata[15:0];
      end else if (state_reg == READ) begin
        cnt_reg <= cnt_reg + 3'd1;
      end
    end
  end

  assign req_ready   = (state_reg == IDLE);
  assign ram_wren    = ram_wren_reg;
  assign ram_address = ram_address_reg;
  assign ram_data    = ram_data_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_rdata   = rsp_rdata_reg;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Scoreboard bench for lsu_ram_ctrl with a 2-cycle-latency RAM model.
// Stimulus pushes expected responses/writes with their due cycle; a negedge monitor pops and compares.
module tb_lsu_ram_ctrl;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [10:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  lsu_ram_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address sampled at one edge, data visible after the second edge.
  logic [31:0] mem [0:2047];
  logic [31:0] pipe1;
  logic        preload_en;
  always @(posedge clk) begin
    if (preload_en) begin
      mem[3] <= 32'h8899AABB;
      mem[1] <= 32'h0;
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    pipe1 <= mem[ram_address];
    ram_q <= pipe1;
  end

  typedef struct { int due; logic err; logic [31:0] rdata; } rsp_t;
  typedef struct { int due; logic [10:0] addr; logic [31:0] data; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) fail("unexpected_rsp");
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          $display("rsp cyc=%0d err=%0b rdata=%h", cyc, rsp_err, rsp_rdata);
          check("rsp_cycle", 32'(cyc), 32'(e.due));
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
      if (ram_wren) begin
        if (wr_q.size() == 0) fail("unexpected_wren");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          $display("ram write cyc=%0d addr=%0d data=%h", cyc, ram_address, ram_data);
          check("wr_cycle", 32'(cyc), 32'(w.due));
          check("wr_addr", {21'b0, ram_address}, {21'b0, w.addr});
          check("wr_data", ram_data, w.data);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [12:0] addr,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                       input int rsp_lat, input int wr_lat, input logic [31:0] wr_data,
                       input logic keep, output int acc);
    int k;
    rsp_t r;
    wr_t  w;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) fail("accept_timeout");
    acc = cyc;
    if (rsp_lat > 0) begin
      r.due = acc + rsp_lat; r.err = exp_err; r.rdata = exp_rd;
      rsp_q.push_back(r);
    end
    if (wr_lat > 0) begin
      w.due = acc + wr_lat; w.addr = addr[12:2]; w.data = wr_data;
      wr_q.push_back(w);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) fail("drain_timeout");
    @(negedge clk);
  endtask

  task automatic load(input logic [2:0] f3, input logic [12:0] addr, input logic [31:0] exp, input logic keep = 1'b0);
    int acc;
    issue(1'b0, f3, addr, 32'h0, 1'b0, exp, RD_LAT + 2, 0, 32'h0, keep, acc);
    last_rd = exp;
  endtask

  task automatic store_w(input logic [12:0] addr, input logic [31:0] wd);
    int acc;
    issue(1'b1, 3'b010, addr, wd, 1'b0, last_rd, 2, 1, wd, 1'b0, acc);
    drain();
  endtask

  task automatic store_sub(input logic [2:0] f3, input logic [12:0] addr, input logic [31:0] wd, input logic [31:0] merged);
    int acc;
    issue(1'b1, f3, addr, wd, 1'b0, last_rd, RD_LAT + 3, RD_LAT + 2, merged, 1'b0, acc);
    drain();
  endtask

  task automatic bad_req(input logic we, input logic [2:0] f3, input logic [12:0] addr);
    int acc;
    issue(we, f3, addr, 32'hA5A5A5A5, 1'b1, last_rd, 1, 0, 32'h0, 1'b0, acc);
    drain();
  endtask

  initial begin
    int a1, a2, acc;
    rst = 1'b1; preload_en = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    #1 rst = 1'b0;
    #2;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_ram_wren", {31'b0, ram_wren}, 32'h0);
    check("reset_ram_address", {21'b0, ram_address}, 32'h0);
    check("reset_ram_data", ram_data, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, req_ready}, 32'h1);

    store_w(13'h004, 32'hDEADBEEF);
    load(3'b000, 13'h00F, 32'hFFFFFF88); drain();
    load(3'b100, 13'h00F, 32'h00000088); drain();
    load(3'b101, 13'h00C, 32'h0000AABB); drain();
    load(3'b001, 13'h00E, 32'hFFFF8899); drain();
    load(3'b101, 13'h00E, 32'h00008899); drain();
    load(3'b000, 13'h00C, 32'hFFFFFFBB); drain();
    load(3'b010, 13'h004, 32'hDEADBEEF); drain();

    store_sub(3'b000, 13'h00D, 32'hFFFFFF12, 32'h889912BB);
    load(3'b010, 13'h00C, 32'h889912BB); drain();

    bad_req(1'b0, 3'b001, 13'h003);
    bad_req(1'b1, 3'b010, 13'h006);
    bad_req(1'b0, 3'b010, 13'h00E);
    bad_req(1'b0, 3'b011, 13'h000);
    bad_req(1'b1, 3'b100, 13'h00C);
    bad_req(1'b1, 3'b101, 13'h00C);

    store_sub(3'b001, 13'h006, 32'h5555CAFE, 32'hCAFEBEEF);
    load(3'b010, 13'h004, 32'hCAFEBEEF); drain();

    // Abort a sub-word store mid-read: no write, no response may follow.
    issue(1'b1, 3'b001, 13'h00C, 32'h00001234, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0, acc);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_ready", {31'b0, req_ready}, 32'h1);
    check("abort_wren", {31'b0, ram_wren}, 32'h0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("abort_rsp_rdata", rsp_rdata, 32'h0);
    last_rd = 32'h0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_mem_word3", mem[3], 32'h889912BB);
    load(3'b010, 13'h00C, 32'h889912BB); drain();

    issue(1'b0, 3'b010, 13'h00C, 32'h0, 1'b0, 32'h889912BB, RD_LAT + 2, 0, 32'h0, 1'b1, a1);
    issue(1'b0, 3'b010, 13'h004, 32'h0, 1'b0, 32'hCAFEBEEF, RD_LAT + 2, 0, 32'h0, 1'b0, a2);
    last_rd = 32'hCAFEBEEF;
    check("b2b_accept_gap", 32'(a2 - a1), 32'd5);
    drain();

    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ram_ctrl.md
LSU_RAM_CTRL -- requirements
Module: lsu_ram_ctrl

Interface
REQ-001 SHALL have parameter: RD_LAT, default 2, clock edges from ram_address driven to ram_q valid (legal 1..4).
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  1  load/store request present.
REQ-005 SHALL have port: req_ready  out  1  block idle, request accepted when req_valid&&req_ready at a rising edge.
REQ-006 SHALL have port: req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port: req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port: req_addr  in  13  byte address.
REQ-009 SHALL have port: req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  out  32  extended load data.
REQ-012 SHALL have port: rsp_err  out  1  misaligned or illegal request, qualified by rsp_valid.
REQ-013 SHALL have port: ram_address  out  11  word address to single-port RAM (req_addr[12:2]).
REQ-014 SHALL have port: ram_data  out  32  RAM write data.
REQ-015 SHALL have port: ram_wren  out  1  RAM write enable.
REQ-016 SHALL have port: ram_q  in  32  RAM read data.

Function
REQ-017 SHALL implement FSM states IDLE, READ, MERGE, WRITE, RESP; req_ready=1 only in IDLE; RAM-side outputs and rsp_* registered.
REQ-018 SHALL number cycles from acceptance edge: cycle 0 = handshake cycle, cycle k = k clocks later.
REQ-019 SHALL flag error for: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111; store with funct3 100/101.
REQ-020 SHALL on error go IDLE->RESP: rsp_valid=1, rsp_err=1 in cycle 1, ram_wren never asserted, rsp_rdata unchanged.
REQ-021 SHALL on aligned SW go IDLE->WRITE: ram_wren=1, ram_address=addr[12:2], ram_data=wdata in cycle 1; RESP (rsp_valid=1, rsp_err=0) in cycle 2.
REQ-022 SHALL on load go IDLE->READ: ram_address held cycles 1..RD_LAT+1, ram_q captured at end of cycle RD_LAT+1, RESP in cycle RD_LAT+2.
REQ-023 SHALL extend loads little-endian: B/BU select byte lane addr[1:0], H/HU select half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W passes 32 bits.
REQ-024 SHALL on SB/SH read as REQ-022, then MERGE->WRITE: ram_wren=1 in cycle RD_LAT+2 with captured word, lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH); RESP in cycle RD_LAT+3.
REQ-025 SHALL keep ram_wren high for exactly one cycle per store and zero for loads/errors.
REQ-026 SHALL hold rsp_rdata until the next successful load response; stores and errors leave it unchanged.
REQ-027 SHALL ignore req_* while not in IDLE; RESP always returns to IDLE, next acceptance earliest in cycle after rsp_valid.
REQ-028 SHALL treat ram_address wrap as none: 11-bit field, addresses 0x000-0x1FFF map directly.

Reset
REQ-029 SHALL on rst low, asynchronously: state IDLE, ram_wren=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_address=0, ram_data=0.
REQ-030 SHALL abort any in-flight operation on reset without a RAM write or response; req_ready=1 from first edge after release.

Verification (RD_LAT=2, word 3 preloaded 0x8899AABB)
REQ-031 SW addr 0x004 wdata 0xDEADBEEF -> cycle 1 ram_wren=1, ram_address=1, ram_data=0xDEADBEEF; cycle 2 rsp_valid=1, rsp_err=0.
REQ-032 LB addr 0x00F -> cycle 4 rsp_rdata=0xFFFFFF88; LBU same addr -> 0x00000088; LHU 0x00C -> 0x0000AABB; ram_wren stays 0.
REQ-033 SB addr 0x00D wdata 0x12 -> cycle 4 ram_wren=1, ram_data=0x889912BB; cycle 5 rsp_valid; following LW 0x00C returns 0x889912BB.
REQ-034 LH addr 0x003, then SW 0x006 -> each rsp_valid=1, rsp_err=1 in cycle 1, ram_wren never high, rsp_rdata unchanged.
REQ-035 SH 0x00C, rst low in cycle 2 for 1 cycle -> ram_wren never high, no rsp_valid, word 3 unchanged; next LW 0x00C returns original word.
REQ-036 req_valid held high for two back-to-back LW -> req_ready=0 cycles 1..4, second accepted cycle 5, second rsp_valid cycle 9.
